rv32imf_mem_arbiter: RTL and testbench

RV32IMF_MEM_ARBITER -- requirements
Module: rv32imf_mem_arbiter

---
 rtl/rv32imf_pkg.sv | 26 ++
 rtl/rv32imf_mem_arbiter_if.sv | 57 +++++
 rtl/rv32imf_arb_id_fifo.sv | 79 +++++++
 rtl/rv32imf_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_rv32imf_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32imf_pkg.sv
// Shared types and constants for the rv32imf memory arbiter.
// Contents: arbiter FSM state enum, requester IDs, bus widths and the
// request payload struct that is captured while a request waits for grant.
package rv32imf_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    localparam logic ARB_ID_INSTR = 1'b0;
    localparam logic ARB_ID_DATA  = 1'b1;

    // One shared-bus request as presented on mem_*
    typedef struct packed {
        logic            id;
        logic [XLEN-1:0] addr;
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/rv32imf_mem_arbiter_if.sv
// Bus bundle between fetch/load-store requesters, the arbiter and memory.
// Signals:
//   instr_*  : fetch request (req/addr in), grant and response (out)
//   data_*   : load-store request (req/addr/we/be/wdata in), grant and response (out)
//   mem_*    : shared bus request (out), grant and in-order response (in)
//   busy_o   : arbiter has outstanding work
// Modports: slave = arbiter side, master = requester/memory side.
interface rv32imf_mem_arbiter_if;
    import rv32imf_pkg::*;

    logic            instr_req_i;
    logic [XLEN-1:0] instr_addr_i;
    logic            instr_gnt_o;
    logic            instr_rvalid_o;
    logic [XLEN-1:0] instr_rdata_o;

    logic            data_req_i;
    logic [XLEN-1:0] data_addr_i;
    logic            data_we_i;
    logic [BE_W-1:0] data_be_i;
    logic [XLEN-1:0] data_wdata_i;
    logic            data_gnt_o;
    logic            data_rvalid_o;
    logic [XLEN-1:0] data_rdata_o;

    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_we_o;
    logic [BE_W-1:0] mem_be_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    logic            busy_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output busy_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  busy_o
    );

endinterface

// File: rtl/rv32imf_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered bus transactions.
// Ports:
//   clk, rst   : clock, async active-high reset (empties the FIFO)
//   push_i     : store push_id_i (ignored when full)
//   push_id_i  : requester ID of the granted transaction
//   pop_i      : drop the head entry (ignored when empty)
//   head_o     : ID of the oldest outstanding transaction
//   full_o     : cnt_o == DEPTH
//   empty_o    : cnt_o == 0
//   cnt_o      : number of stored IDs
module rv32imf_arb_id_fifo #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             push_id_i,
    input  logic             pop_i,
    output logic             head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/rv32imf_mem_arbiter.sv
// Two-requester (fetch, load-store) arbiter onto one in-order memory bus.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rv32imf_mem_arbiter_if.slave (requester, memory and busy signals)
// Parameter MAX_OUTSTANDING (1..8): granted-but-unanswered transaction limit.
// Build option: define RV32IMF_ARB_RR_EN for round-robin arbitration;
// otherwise data requests always beat instruction requests.
// Grants and response routing are combinational; a request that waits for
// grant is captured and held stable on mem_* until accepted.
module rv32imf_mem_arbiter
    import rv32imf_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    rv32imf_mem_arbiter_if.slave       bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e       state_q, state_d;
    arb_req_t         hold_q, hold_d;
    arb_req_t         live_req, cur_req;
    logic             win_id;
    logic             mem_req;
    logic             grant;
    logic             rsp_hit;
    logic             fifo_head, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
`ifdef RV32IMF_ARB_RR_EN
    logic             rr_q, rr_d;
`endif

    // Winner among live requesters (only meaningful in ARB_IDLE)
    always_comb begin
        win_id = ARB_ID_DATA;
`ifdef RV32IMF_ARB_RR_EN
        if (bus.instr_req_i && bus.data_req_i) begin
            win_id = rr_q;
        end else if (bus.instr_req_i) begin
            win_id = ARB_ID_INSTR;
        end
`else
        if (!bus.data_req_i) begin
            win_id = ARB_ID_INSTR;
        end
`endif
    end

    // Request payload of the live winner; fetches are full-word reads
    always_comb begin
        live_req    = '0;
        live_req.id = win_id;
        if (win_id == ARB_ID_DATA) begin
            live_req.addr  = bus.data_addr_i;
            live_req.we    = bus.data_we_i;
            live_req.be    = bus.data_be_i;
            live_req.wdata = bus.data_wdata_i;
        end else begin
            live_req.addr  = bus.instr_addr_i;
            live_req.we    = 1'b0;
            live_req.be    = '1;
            live_req.wdata = '0;
        end
    end

    assign cur_req = (state_q == ARB_HOLD) ? hold_q : live_req;
    // No request while the ID FIFO is full, even if a response lands this cycle
    assign mem_req = !rst && !fifo_full &&
                     ((state_q == ARB_HOLD) || bus.instr_req_i || bus.data_req_i);
    assign grant   = mem_req && bus.mem_gnt_i;
    assign rsp_hit = !rst && bus.mem_rvalid_i && !fifo_empty;

    // Arbiter FSM next state and request capture
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
`ifdef RV32IMF_ARB_RR_EN
        rr_d    = rr_q;
        if (grant) begin
            rr_d = ~cur_req.id;
        end
`endif
        case (state_q)
            ARB_IDLE: begin
                if (mem_req && !bus.mem_gnt_i) begin
                    state_d = ARB_HOLD;
                    hold_d  = live_req;
                end
            end
            ARB_HOLD: begin
                if (grant) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            hold_q  <= '0;
`ifdef RV32IMF_ARB_RR_EN
            rr_q    <= ARB_ID_DATA;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
`ifdef RV32IMF_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    rv32imf_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (grant),
        .push_id_i (cur_req.id),
        .pop_i     (rsp_hit),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .cnt_o     (fifo_cnt)
    );

    // Bus request side
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = mem_req ? cur_req.addr  : '0;
    assign bus.mem_we_o    = mem_req ? cur_req.we    : 1'b0;
    assign bus.mem_be_o    = mem_req ? cur_req.be    : '0;
    assign bus.mem_wdata_o = mem_req ? cur_req.wdata : '0;

    // Grants and response routing to the requesters
    assign bus.instr_gnt_o    = grant && (cur_req.id == ARB_ID_INSTR);
    assign bus.data_gnt_o     = grant && (cur_req.id == ARB_ID_DATA);
    assign bus.instr_rvalid_o = rsp_hit && (fifo_head == ARB_ID_INSTR);
    assign bus.data_rvalid_o  = rsp_hit && (fifo_head == ARB_ID_DATA);
    assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.data_rdata_o   = bus.data_rvalid_o  ? bus.mem_rdata_i : '0;
    assign bus.busy_o         = !rst && ((fifo_cnt != '0) || mem_req);

    // A response with nothing outstanding is dropped; flag it in simulation
    always_ff @(posedge clk) begin
        if (!rst) begin
            stray_rvalid: assert (!(bus.mem_rvalid_i && fifo_empty))
                else $warning("rv32imf_mem_arbiter: rvalid with no outstanding request dropped");
        end
    end

endmodule

// File: tb/tb_rv32imf_mem_arbiter.sv
// Scoreboard bench for rv32imf_mem_arbiter (MAX_OUTSTANDING = 2).
module tb_rv32imf_mem_arbiter;
    import rv32imf_pkg::*;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic rr_mode;

    arb_req_t exp_gnt_q[$];
    rsp_t     exp_rsp_q[$];

    rv32imf_mem_arbiter_if bus_if ();

    rv32imf_mem_arbiter #(
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_i(input logic [31:0] addr, input logic [31:0] rdata);
        arb_req_t g;
        rsp_t     r;
        g.id = ARB_ID_INSTR; g.addr = addr; g.we = 1'b0; g.be = 4'hF; g.wdata = 32'h0;
        r.id = ARB_ID_INSTR; r.data = rdata;
        exp_gnt_q.push_back(g);
        exp_rsp_q.push_back(r);
    endtask

    task automatic exp_d(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] rdata);
        arb_req_t g;
        rsp_t     r;
        g.id = ARB_ID_DATA; g.addr = addr; g.we = we; g.be = be; g.wdata = wdata;
        r.id = ARB_ID_DATA; r.data = rdata;
        exp_gnt_q.push_back(g);
        exp_rsp_q.push_back(r);
    endtask

    task automatic set_instr(input logic req, input logic [31:0] addr);
        bus_if.instr_req_i  = req;
        bus_if.instr_addr_i = addr;
    endtask

    task automatic set_data(input logic req, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wdata);
        bus_if.data_req_i   = req;
        bus_if.data_addr_i  = addr;
        bus_if.data_we_i    = we;
        bus_if.data_be_i    = be;
        bus_if.data_wdata_i = wdata;
    endtask

    task automatic set_rsp(input logic valid, input logic [31:0] rdata);
        bus_if.mem_rvalid_i = valid;
        bus_if.mem_rdata_i  = rdata;
    endtask

    // Monitor: pops expectations whenever the DUT grants or responds
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.instr_gnt_o && bus_if.data_gnt_o) chk("dual_gnt", 32'd1, 32'd0);
            if (bus_if.mem_req_o && bus_if.mem_gnt_i) begin
                if (exp_gnt_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_grant: got addr 0x%08h expected no grant", bus_if.mem_addr_o);
                end else begin
                    arb_req_t g;
                    g = exp_gnt_q.pop_front();
                    chk("gnt_instr", 32'(bus_if.instr_gnt_o), 32'(g.id == ARB_ID_INSTR));
                    chk("gnt_data",  32'(bus_if.data_gnt_o),  32'(g.id == ARB_ID_DATA));
                    chk("gnt_addr",  bus_if.mem_addr_o, g.addr);
                    chk("gnt_we",    32'(bus_if.mem_we_o), 32'(g.we));
                    chk("gnt_be",    32'(bus_if.mem_be_o), 32'(g.be));
                    chk("gnt_wdata", bus_if.mem_wdata_o, g.wdata);
                end
            end else if (bus_if.instr_gnt_o || bus_if.data_gnt_o) begin
                chk("gnt_without_bus_grant", 32'd1, 32'd0);
            end
            if (bus_if.instr_rvalid_o || bus_if.data_rvalid_o) begin
                if (exp_rsp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp: got instr_rvalid=%0b data_rvalid=%0b expected none",
                             bus_if.instr_rvalid_o, bus_if.data_rvalid_o);
                end else begin
                    rsp_t r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_instr_valid", 32'(bus_if.instr_rvalid_o), 32'(r.id == ARB_ID_INSTR));
                    chk("rsp_data_valid",  32'(bus_if.data_rvalid_o),  32'(r.id == ARB_ID_DATA));
                    chk("rsp_instr_rdata", bus_if.instr_rdata_o, (r.id == ARB_ID_INSTR) ? r.data : 32'h0);
                    chk("rsp_data_rdata",  bus_if.data_rdata_o,  (r.id == ARB_ID_DATA)  ? r.data : 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
`ifdef RV32IMF_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        rst = 1'b1;
        set_instr(1'b0, 32'h0);
        set_data(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        set_rsp(1'b0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: outputs held at zero even with live inputs
        set_instr(1'b1, 32'h100);
        bus_if.mem_gnt_i = 1'b1;
        set_rsp(1'b1, 32'hFFFF_0000);
        @(negedge clk);
        chk("rst_mem_req", 32'(bus_if.mem_req_o), 32'd0);
        chk("rst_busy",    32'(bus_if.busy_o), 32'd0);
        chk("rst_gnts",    32'({bus_if.instr_gnt_o, bus_if.data_gnt_o}), 32'd0);
        chk("rst_rvalids", 32'({bus_if.instr_rvalid_o, bus_if.data_rvalid_o}), 32'd0);
        chk("rst_addr",    bus_if.mem_addr_o, 32'h0);
        tick();
        set_instr(1'b0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b0, 32'h0);
        rst = 1'b0;
        tick();

        // Both requesting continuously: RR alternates D,I,D,I; fixed gives D x4
        for (int k = 0; k < 4; k++) begin
            if (rr_mode && (k % 2 == 1)) exp_i(32'h100, 32'h5100_0000 + 32'(k));
            else exp_d(32'h200, 1'b0, 4'hF, 32'h0, 32'h5100_0000 + 32'(k));
        end
        set_instr(1'b1, 32'h100);
        set_data(1'b1, 32'h200, 1'b0, 4'hF, 32'h0);
        bus_if.mem_gnt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            set_rsp(1'b1, 32'h5100_0000 + 32'(k));
        end
        tick();
        set_instr(1'b0, 32'h0);
        set_data(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b1, 32'h5100_0003);
        tick();
        set_rsp(1'b0, 32'h0);
        tick();

        // Simultaneous requests: data first, instruction next cycle
        exp_d(32'h200, 1'b0, 4'hF, 32'h0, 32'h1111);
        exp_i(32'h100, 32'h2222);
        set_instr(1'b1, 32'h100);
        set_data(1'b1, 32'h200, 1'b0, 4'hF, 32'h0);
        bus_if.mem_gnt_i = 1'b1;
        tick();
        set_data(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        tick();
        set_instr(1'b0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b1, 32'h1111);
        tick();
        set_rsp(1'b1, 32'h2222);
        tick();
        set_rsp(1'b0, 32'h0);
        tick();

        // Outstanding limit, no rvalid bypass, push+pop in one cycle
        exp_i(32'h10, 32'hC0);
        exp_i(32'h10, 32'hC1);
        set_instr(1'b1, 32'h10);
        bus_if.mem_gnt_i = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("full_mem_req", 32'(bus_if.mem_req_o), 32'd0);
        chk("full_busy",    32'(bus_if.busy_o), 32'd1);
        tick();
        set_rsp(1'b1, 32'hC0);
        @(negedge clk);
        chk("no_bypass_mem_req", 32'(bus_if.mem_req_o), 32'd0);
        exp_i(32'h10, 32'hC2);
        tick();
        set_rsp(1'b0, 32'h0);
        @(negedge clk);
        chk("reassert_mem_req", 32'(bus_if.mem_req_o), 32'd1);
        tick();
        set_instr(1'b0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b1, 32'hC1);
        tick();
        exp_d(32'h44, 1'b1, 4'hC, 32'hDEAD_BEEF, 32'hD0);
        set_rsp(1'b1, 32'hC2);
        set_data(1'b1, 32'h44, 1'b1, 4'hC, 32'hDEAD_BEEF);
        bus_if.mem_gnt_i = 1'b1;
        tick();
        set_data(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b0, 32'h0);
        @(negedge clk);
        chk("pushpop_busy", 32'(bus_if.busy_o), 32'd1);
        tick();
        set_rsp(1'b1, 32'hD0);
        tick();
        set_rsp(1'b0, 32'h0);
        @(negedge clk);
        chk("drained_busy", 32'(bus_if.busy_o), 32'd0);
        tick();

        // Data write held for three ungranted cycles while instr toggles
        exp_d(32'h40, 1'b1, 4'h3, 32'h1234_5678, 32'h0);
        set_data(1'b1, 32'h40, 1'b1, 4'h3, 32'h1234_5678);
        for (int c = 0; c < 3; c++) begin
            set_instr(c % 2 == 1, 32'h900);
            @(negedge clk);
            chk("hold_req",   32'(bus_if.mem_req_o), 32'd1);
            chk("hold_addr",  bus_if.mem_addr_o, 32'h40);
            chk("hold_be",    32'(bus_if.mem_be_o), 32'h3);
            chk("hold_wdata", bus_if.mem_wdata_o, 32'h1234_5678);
            tick();
        end
        set_instr(1'b0, 32'h0);
        bus_if.mem_gnt_i = 1'b1;
        tick();
        set_data(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b1, 32'h0);
        tick();
        set_rsp(1'b0, 32'h0);
        tick();

        // Held instr winner is not displaced by a later data request
        exp_i(32'h300, 32'h3333);
        exp_d(32'h500, 1'b0, 4'hF, 32'h0, 32'h5555);
        set_instr(1'b1, 32'h300);
        tick();
        set_data(1'b1, 32'h500, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("frozen_addr", bus_if.mem_addr_o, 32'h300);
        chk("frozen_be",   32'(bus_if.mem_be_o), 32'hF);
        tick();
        bus_if.mem_gnt_i = 1'b1;
        tick();
        set_instr(1'b0, 32'h0);
        tick();
        set_data(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b1, 32'h3333);
        tick();
        set_rsp(1'b1, 32'h5555);
        tick();
        set_rsp(1'b0, 32'h0);
        tick();

        // In-order response routing, non-selected rdata is zero
        exp_i(32'h100, 32'hAAAA_0001);
        exp_d(32'h200, 1'b0, 4'hF, 32'h0, 32'hBBBB_0002);
        set_instr(1'b1, 32'h100);
        bus_if.mem_gnt_i = 1'b1;
        tick();
        set_instr(1'b0, 32'h0);
        set_data(1'b1, 32'h200, 1'b0, 4'hF, 32'h0);
        tick();
        set_data(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b1, 32'hAAAA_0001);
        @(negedge clk);
        chk("route_data_rdata_zero", bus_if.data_rdata_o, 32'h0);
        tick();
        set_rsp(1'b1, 32'hBBBB_0002);
        @(negedge clk);
        chk("route_instr_rdata_zero", bus_if.instr_rdata_o, 32'h0);
        tick();
        set_rsp(1'b0, 32'h0);
        tick();

        // Reset with two outstanding; stray rvalid afterwards is dropped
        exp_i(32'h600, 32'h0);
        exp_i(32'h600, 32'h0);
        set_instr(1'b1, 32'h600);
        bus_if.mem_gnt_i = 1'b1;
        tick();
        tick();
        set_instr(1'b0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(bus_if.busy_o), 32'd1);
        tick();
        rst = 1'b1;
        exp_rsp_q.delete();
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus_if.busy_o), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus_if.busy_o), 32'd0);
        tick();
        set_rsp(1'b1, 32'h0000_0BAD);
        @(negedge clk);
        chk("stray_rvalids", 32'({bus_if.instr_rvalid_o, bus_if.data_rvalid_o}), 32'd0);
        chk("stray_gnts",    32'({bus_if.instr_gnt_o, bus_if.data_gnt_o}), 32'd0);
        chk("stray_instr_rdata", bus_if.instr_rdata_o, 32'h0);
        chk("stray_data_rdata",  bus_if.data_rdata_o, 32'h0);
        tick();
        set_rsp(1'b0, 32'h0);
        exp_i(32'h700, 32'h77);
        set_instr(1'b1, 32'h700);
        bus_if.mem_gnt_i = 1'b1;
        tick();
        set_instr(1'b0, 32'h0);
        bus_if.mem_gnt_i = 1'b0;
        set_rsp(1'b1, 32'h77);
        tick();
        set_rsp(1'b0, 32'h0);

        repeat (3) tick();
        chk("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
        chk("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
